gbp_ghr_ckpt: RTL and testbench
===============================

# gbp_ghr_ckpt

Speculative global history register with checkpoint recovery. It sits directly upstream of the global branch predictor and supplies the history used to index the pattern table. Each conditional-branch prediction shifts its predicted direction into the history and allocates a checkpoint tag. A resolved misprediction restores the history from that checkpoint with the correct outcome shifted in.

## Interface
- HIST_LEN, 16: history width in bits (≥2).
- NR_CKPT, 8: number of checkpoints; power of 2, ≥2. TAG_W = $clog2(NR_CKPT).
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  full frontend flush: drop all checkpoints, restore committed history.
- spec_valid_i  in  1  conditional branch predicted this cycle.
- spec_taken_i  in  1  predicted direction.
- spec_ready_o  out  1  checkpoint can be allocated this cycle.
- spec_tag_o  out  TAG_W  tag assigned to the branch if accepted this cycle.
- ghr_o  out  HIST_LEN  speculative history, registered, bit 0 = newest.
- resolve_valid_i  in  1  a branch resolved.
- resolve_tag_i  in  TAG_W  tag of the resolving branch.
- resolve_mispredict_i  in  1  prediction was wrong.
- resolve_taken_i  in  1  actual direction.
- commit_ghr_o  out  HIST_LEN  non-speculative history built from retired branches.

## Operation
- Circular buffer of NR_CKPT entries, each holding: valid, resolved, outcome bit, snapshot of ghr before the branch. Pointers head, tail (TAG_W bits, wrap modulo NR_CKPT), count (TAG_W+1 bits).
- Reset: ghr, commit_ghr, head, tail, count = 0; all valid/resolved = 0. Outputs after reset: ghr_o=0, commit_ghr_o=0, spec_ready_o=1, spec_tag_o=0.
- spec_ready_o = (count != NR_CKPT) && !flush_i && !(resolve_valid_i && resolve_mispredict_i).
- spec_tag_o = tail, combinational.
- Accept (spec_valid_i && spec_ready_o): entry[tail] ← {valid=1, resolved=0, outcome=spec_taken_i, snapshot=ghr}. Then ghr ← {ghr[HIST_LEN-2:0], spec_taken_i}, tail+1, count+1.
- Correct resolve (valid entry): resolved=1, outcome ← resolve_taken_i. ghr is unchanged.
- Mispredict on tag t:
  - ghr ← {snapshot[t][HIST_LEN-2:0], resolve_taken_i}.
  - Entry t becomes resolved with outcome ← resolve_taken_i.
  - All entries younger than t (t+1 up to tail-1) are invalidated.
  - tail ← t+1; count ← (t+1−head) mod NR_CKPT. Count is NR_CKPT when that result is 0 and the buffer was full with t = head−1.
- Retire: when count≠0 and entry[head].resolved (registered state), commit_ghr ← {commit_ghr[HIST_LEN-2:0], outcome[head]}, invalidate head, head+1, count−1. At most one retire per cycle.
- flush_i: ghr ← commit_ghr, all entries invalid, head=tail=count=0. Same-cycle spec, resolve and retire are ignored. The retire that would have happened that cycle does not update commit_ghr.
- Priority: rst_i > flush_i > mispredict > spec accept. A correct resolve and a spec accept in the same cycle are independent. Retire runs concurrently with spec accept and with either resolve kind, and count accounts for both.
- A resolve to an invalid tag is ignored (no state change).

## Timing
- ghr_o and commit_ghr_o are registered and change one cycle after the accept, mispredict or retire that causes them.
- A resolve in cycle N lets the entry retire in cycle N+1 (if it is head), and commit_ghr_o updates at the N+1→N+2 edge.
- A mispredict in cycle N gives the corrected ghr_o in cycle N+1, and the first correct-path branch can be accepted in N+1.
- When full, spec_ready_o re-asserts in the cycle after the head retires.

## Configuration
- GBP_GHR_PERF_EN: when defined, adds ports mispredict_cnt_o (out, 32) and ckpt_full_cnt_o (out, 32).
  - Both reset to 0 and saturate at 32'hFFFF_FFFF.
  - mispredict_cnt_o counts accepted mispredicts on valid tags.
  - ckpt_full_cnt_o counts cycles with spec_valid_i=1 while count==NR_CKPT.
  - When undefined, the ports and counters do not exist and all other behaviour is identical.

## Test plan
- Reset: assert rst_i for 2 cycles with random inputs -> ghr_o=0, commit_ghr_o=0, spec_ready_o=1, spec_tag_o=0.
- Predict T,N,T on consecutive cycles -> tags 0,1,2; ghr_o=16'h0005 one cycle after the third accept.
- From ghr_o=16'h0005 (tags 0–2 live), resolve tag 1 as a mispredict with taken=1 -> next cycle ghr_o=16'h0003, spec_tag_o=2, entry 2 invalid. A later resolve of tag 2 is ignored.
- Accept 8 predictions -> spec_ready_o=0, and a 9th spec_valid_i is dropped (ckpt_full_cnt_o=1 with GBP_GHR_PERF_EN). Resolve tag 0 correct in cycle N -> retire in N+1, spec_ready_o=1 in N+2.
- In the same cycle: mispredict on tag 0 (taken=0) and spec_valid_i=1 -> spec dropped, ghr_o = snapshot<<1, count=1.
- Predict T,T, resolve both correct, let them retire, predict N, then flush_i -> commit_ghr_o=16'h0003 and ghr_o=16'h0003 the next cycle, count=0.

Source files
------------

// File: rtl/gbp_ghr_ckpt.sv
// -----------------------------------------------------------------------------
// gbp_ghr_ckpt
// Speculative global history register with checkpoint recovery. Feeds the
// global branch predictor's pattern-table index. Every accepted conditional
// branch prediction shifts its predicted direction into the history and takes
// a checkpoint tag. A resolved misprediction rebuilds the history from that
// checkpoint's snapshot with the real outcome shifted in. Resolved branches
// retire in order from the head and build the committed history.
//
// Ports:
//   clk_i                 clock
//   rst_i                 synchronous active-high reset
//   flush_i               full frontend flush (history <- committed history)
//   spec_valid_i/taken_i  conditional branch predicted this cycle + direction
//   spec_ready_o          a checkpoint can be allocated this cycle
//   spec_tag_o            tag handed to the branch if accepted this cycle
//   ghr_o                 speculative history, registered, bit 0 = newest
//   resolve_valid_i/tag_i/mispredict_i/taken_i   branch resolution
//   commit_ghr_o          non-speculative history from retired branches
//
// Optional build macro GBP_GHR_PERF_EN adds saturating counters:
//   mispredict_cnt_o      accepted mispredicts on live tags
//   ckpt_full_cnt_o       cycles with spec_valid_i=1 while all checkpoints used
// -----------------------------------------------------------------------------
module gbp_ghr_ckpt #(
  parameter int  HIST_LEN = 16,
  parameter int  NR_CKPT  = 8,
  localparam int TAG_W    = $clog2(NR_CKPT)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                spec_valid_i,
  input  logic                spec_taken_i,
  output logic                spec_ready_o,
  output logic [TAG_W-1:0]    spec_tag_o,
  output logic [HIST_LEN-1:0] ghr_o,
  input  logic                resolve_valid_i,
  input  logic [TAG_W-1:0]    resolve_tag_i,
  input  logic                resolve_mispredict_i,
  input  logic                resolve_taken_i,
  output logic [HIST_LEN-1:0] commit_ghr_o
`ifdef GBP_GHR_PERF_EN
  ,
  output logic [31:0]         mispredict_cnt_o,
  output logic [31:0]         ckpt_full_cnt_o
`endif
);

  localparam logic [TAG_W:0]   FULL_CNT = (TAG_W + 1)'(NR_CKPT);
  localparam logic [TAG_W:0]   CNT_ONE  = (TAG_W + 1)'(1);
  localparam logic [TAG_W-1:0] TAG_ONE  = TAG_W'(1);

  // Architectural state
  logic [HIST_LEN-1:0] ghr_q, commit_ghr_q;
  logic [TAG_W-1:0]    head_q, tail_q;
  logic [TAG_W:0]      count_q;
  logic [NR_CKPT-1:0]  valid_q, resolved_q, outcome_q;
  logic [HIST_LEN-1:0] snap_q [NR_CKPT];

  // Next-state
  logic [HIST_LEN-1:0] ghr_d, commit_ghr_d;
  logic [TAG_W-1:0]    head_d, tail_d;
  logic [TAG_W:0]      count_d;
  logic [NR_CKPT-1:0]  valid_d, resolved_d, outcome_d;

  // Decoded events
  logic                mispredict_req, tag_live;
  logic                accept, do_mispredict, do_correct, do_retire;
  logic [TAG_W-1:0]    mp_next, mp_span, mp_offset, entry_offset;
  logic [TAG_W:0]      mp_count;

  assign mispredict_req = resolve_valid_i && resolve_mispredict_i;
  assign spec_ready_o   = (count_q != FULL_CNT) && !flush_i && !mispredict_req;
  assign spec_tag_o     = tail_q;
  assign ghr_o          = ghr_q;
  assign commit_ghr_o   = commit_ghr_q;

  assign accept        = spec_valid_i && spec_ready_o;
  assign tag_live      = valid_q[resolve_tag_i];
  assign do_mispredict = mispredict_req && tag_live && !flush_i;
  assign do_correct    = resolve_valid_i && !resolve_mispredict_i && tag_live && !flush_i;
  // Retire looks only at registered resolved state, so a resolve in cycle N
  // retires in N+1 at the earliest.
  assign do_retire     = (count_q != '0) && resolved_q[head_q] && !flush_i;

  // After a mispredict on tag t the live window is head..t. The span wraps to
  // zero only when t = head-1 with the buffer full, i.e. nothing is dropped.
  assign mp_next   = resolve_tag_i + TAG_ONE;
  assign mp_span   = mp_next - head_q;
  assign mp_offset = resolve_tag_i - head_q;
  assign mp_count  = (mp_span == '0) ? FULL_CNT : {1'b0, mp_span};

  // NOTE: every variable gets its default at the top of the block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    valid_d      = valid_q;
    resolved_d   = resolved_q;
    outcome_d    = outcome_q;
    entry_offset = '0;

    if (do_correct || do_mispredict) begin
      resolved_d[resolve_tag_i] = 1'b1;
      outcome_d[resolve_tag_i]  = resolve_taken_i;
    end

    // Drop everything younger than the mispredicted branch: entries whose
    // age offset from head exceeds that of the resolving tag.
    if (do_mispredict) begin
      for (int i = 0; i < NR_CKPT; i++) begin
        entry_offset = TAG_W'(i) - head_q;
        if (entry_offset > mp_offset) begin
          valid_d[i]    = 1'b0;
          resolved_d[i] = 1'b0;
        end
      end
    end

    if (accept) begin
      valid_d[tail_q]    = 1'b1;
      resolved_d[tail_q] = 1'b0;
      outcome_d[tail_q]  = spec_taken_i;
    end

    if (do_retire) begin
      valid_d[head_q]    = 1'b0;
      resolved_d[head_q] = 1'b0;
    end

    if (flush_i) begin
      valid_d    = '0;
      resolved_d = '0;
    end
  end

  always_comb begin
    ghr_d        = ghr_q;
    commit_ghr_d = commit_ghr_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;

    if (flush_i) begin
      ghr_d   = commit_ghr_q;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_mispredict) begin
        ghr_d   = {snap_q[resolve_tag_i][HIST_LEN-2:0], resolve_taken_i};
        tail_d  = mp_next;
        count_d = mp_count;
      end else if (accept) begin
        ghr_d   = {ghr_q[HIST_LEN-2:0], spec_taken_i};
        tail_d  = tail_q + TAG_ONE;
        count_d = count_q + CNT_ONE;
      end

      if (do_retire) begin
        commit_ghr_d = {commit_ghr_q[HIST_LEN-2:0], outcome_q[head_q]};
        head_d       = head_q + TAG_ONE;
        count_d      = count_d - CNT_ONE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ghr_q        <= '0;
      commit_ghr_q <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      valid_q      <= '0;
      resolved_q   <= '0;
      outcome_q    <= '0;
    end else begin
      ghr_q        <= ghr_d;
      commit_ghr_q <= commit_ghr_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      valid_q      <= valid_d;
      resolved_q   <= resolved_d;
      outcome_q    <= outcome_d;
    end
  end

  // NOTE: the snapshot array has no reset; an entry is only read while its
  // valid bit is set, and valid is always written together with the snapshot.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      snap_q[tail_q] <= ghr_q;
    end
  end

`ifdef GBP_GHR_PERF_EN
  logic [31:0] mispredict_cnt_q, ckpt_full_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mispredict_cnt_q <= '0;
      ckpt_full_cnt_q  <= '0;
    end else begin
      if (do_mispredict && (mispredict_cnt_q != '1)) begin
        mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
      end
      if (spec_valid_i && (count_q == FULL_CNT) && (ckpt_full_cnt_q != '1)) begin
        ckpt_full_cnt_q <= ckpt_full_cnt_q + 32'd1;
      end
    end
  end

  assign mispredict_cnt_o = mispredict_cnt_q;
  assign ckpt_full_cnt_o  = ckpt_full_cnt_q;
`endif

endmodule

// File: tb/tb_gbp_ghr_ckpt.sv
// -----------------------------------------------------------------------------
// tb_gbp_ghr_ckpt
// Scoreboard bench for gbp_ghr_ckpt. The stimulus process drives one cycle at
// a time, asks a queue-based reference model for the outputs that cycle should
// show, and pushes them to a scoreboard queue. A monitor process samples the
// DUT on the falling edge, pops and compares. Directed spec values are attached
// to particular cycles as "pins" and compared by the same monitor.
// Optional build macro GBP_GHR_PERF_EN also checks the performance counters.
// -----------------------------------------------------------------------------
module tb_gbp_ghr_ckpt;

  localparam int HL = 16;
  localparam int NR = 8;
  localparam int TW = 3;

  localparam int SEL_GHR    = 0;
  localparam int SEL_COMMIT = 1;
  localparam int SEL_READY  = 2;
  localparam int SEL_TAG    = 3;
  localparam int SEL_FULL   = 4;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          flush_i = 1'b0;
  logic          spec_valid_i = 1'b0;
  logic          spec_taken_i = 1'b0;
  logic          spec_ready_o;
  logic [TW-1:0] spec_tag_o;
  logic [HL-1:0] ghr_o;
  logic          resolve_valid_i = 1'b0;
  logic [TW-1:0] resolve_tag_i = '0;
  logic          resolve_mispredict_i = 1'b0;
  logic          resolve_taken_i = 1'b0;
  logic [HL-1:0] commit_ghr_o;
`ifdef GBP_GHR_PERF_EN
  logic [31:0]   mispredict_cnt_o, ckpt_full_cnt_o;
`endif

  gbp_ghr_ckpt #(.HIST_LEN(HL), .NR_CKPT(NR)) dut (
    .clk_i                (clk),
    .rst_i                (rst_i),
    .flush_i              (flush_i),
    .spec_valid_i         (spec_valid_i),
    .spec_taken_i         (spec_taken_i),
    .spec_ready_o         (spec_ready_o),
    .spec_tag_o           (spec_tag_o),
    .ghr_o                (ghr_o),
    .resolve_valid_i      (resolve_valid_i),
    .resolve_tag_i        (resolve_tag_i),
    .resolve_mispredict_i (resolve_mispredict_i),
    .resolve_taken_i      (resolve_taken_i),
    .commit_ghr_o         (commit_ghr_o)
`ifdef GBP_GHR_PERF_EN
    ,
    .mispredict_cnt_o     (mispredict_cnt_o),
    .ckpt_full_cnt_o      (ckpt_full_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- reference model: in-flight branches as a queue ----------
  typedef struct packed {
    logic          resolved;
    logic          outcome;
    logic [HL-1:0] snap;
  } ck_t;

  ck_t           mq[$];       // oldest branch at index 0
  logic [HL-1:0] m_ghr = '0;
  logic [HL-1:0] m_commit = '0;
  int            m_head = 0;  // tag of the oldest in-flight branch
  logic [31:0]   m_mp_cnt = '0;
  logic [31:0]   m_full_cnt = '0;

  typedef struct {
    int            cyc;
    logic [HL-1:0] ghr;
    logic [HL-1:0] commit;
    logic          ready;
    logic [TW-1:0] tag;
    logic [31:0]   mp_cnt;
    logic [31:0]   full_cnt;
  } exp_t;

  typedef struct {
    int          cyc;
    string       nm;
    int          sel;
    logic [31:0] val;
  } pin_t;

  exp_t exp_q[$];
  pin_t pin_q[$];
  pin_t pin_pend[$];
  int   cyc_id = 0;
  bit   done = 1'b0;
  bit   drained = 1'b0;

  int total = 0;
  int bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, want, cyc_id);
    end
  endtask

  // Attach a directed expectation to the next driven cycle.
  task automatic pin(input string nm, input int sel, input logic [31:0] val);
    pin_t p;
    p.cyc = 0;
    p.nm  = nm;
    p.sel = sel;
    p.val = val;
    pin_pend.push_back(p);
  endtask

  // Drive one cycle, record what it should show, then advance the model.
  task automatic cyc(input bit r, input bit f, input bit sv, input bit st,
                     input bit rv, input bit [TW-1:0] rtg, input bit rm, input bit rt);
    exp_t e;
    ck_t  c;
    bit   ready, ret, ret_out;
    int   idx;
    @(posedge clk);
    #1;
    rst_i = r; flush_i = f; spec_valid_i = sv; spec_taken_i = st;
    resolve_valid_i = rv; resolve_tag_i = rtg;
    resolve_mispredict_i = rm; resolve_taken_i = rt;
    cyc_id++;

    ready = (mq.size() != NR) && !f && !(rv && rm);

    if (r) begin
      mq.delete();
      m_ghr = '0; m_commit = '0; m_head = 0;
      m_mp_cnt = '0; m_full_cnt = '0;
      return;
    end

    e.cyc = cyc_id; e.ghr = m_ghr; e.commit = m_commit; e.ready = ready;
    e.tag = TW'((m_head + mq.size()) % NR);
    e.mp_cnt = m_mp_cnt; e.full_cnt = m_full_cnt;
    exp_q.push_back(e);
    while (pin_pend.size() != 0) begin
      pin_t p = pin_pend.pop_front();
      p.cyc = cyc_id;
      pin_q.push_back(p);
    end

    if (sv && mq.size() == NR && m_full_cnt != 32'hFFFF_FFFF) m_full_cnt++;

    if (f) begin
      m_ghr = m_commit;
      mq.delete();
      m_head = 0;
    end else begin
      ret     = (mq.size() != 0) && mq[0].resolved;
      ret_out = ret ? mq[0].outcome : 1'b0;
      idx     = (int'(rtg) - m_head + NR) % NR;
      if (rv && idx < mq.size()) begin
        c = mq[idx];
        c.resolved = 1'b1;
        c.outcome  = rt;
        mq[idx]    = c;
        if (rm) begin
          m_ghr = {c.snap[HL-2:0], rt};
          while (mq.size() > idx + 1) void'(mq.pop_back());
          if (m_mp_cnt != 32'hFFFF_FFFF) m_mp_cnt++;
        end
      end
      if (sv && ready) begin
        c.resolved = 1'b0; c.outcome = st; c.snap = m_ghr;
        mq.push_back(c);
        m_ghr = {m_ghr[HL-2:0], st};
      end
      if (ret) begin
        m_commit = {m_commit[HL-2:0], ret_out};
        void'(mq.pop_front());
        m_head = (m_head + 1) % NR;
      end
    end
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, '0, 0, 0);
  endtask

  // ---------------- monitor / scoreboard ------------------------------------
  always @(negedge clk) begin
    if (done) begin
      check("scoreboard_drained", 32'(drained), 32'd1);
      check("pins_consumed", pin_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end else if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("ghr_o", ghr_o, e.ghr);
      check("commit_ghr_o", commit_ghr_o, e.commit);
      check("spec_ready_o", spec_ready_o, e.ready);
      check("spec_tag_o", spec_tag_o, e.tag);
`ifdef GBP_GHR_PERF_EN
      check("mispredict_cnt_o", mispredict_cnt_o, e.mp_cnt);
      check("ckpt_full_cnt_o", ckpt_full_cnt_o, e.full_cnt);
`endif
      while (pin_q.size() != 0 && pin_q[0].cyc == e.cyc) begin
        pin_t p;
        logic [31:0] act;
        p = pin_q.pop_front();
        case (p.sel)
          SEL_GHR:    act = 32'(ghr_o);
          SEL_COMMIT: act = 32'(commit_ghr_o);
          SEL_READY:  act = 32'(spec_ready_o);
          SEL_TAG:    act = 32'(spec_tag_o);
`ifdef GBP_GHR_PERF_EN
          SEL_FULL:   act = ckpt_full_cnt_o;
`endif
          default:    act = 32'hDEAD_BEEF;
        endcase
        check(p.nm, act, p.val);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ------------------------------------------------
  initial begin
    logic [HL-1:0] snap0;
    int            sz;
    bit [TW-1:0]   rtg;

    // Reset held two cycles with random inputs
    repeat (2) cyc(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   TW'($urandom), 1'($urandom), 1'($urandom));
    pin("rst_ghr", SEL_GHR, 0);
    pin("rst_commit", SEL_COMMIT, 0);
    pin("rst_ready", SEL_READY, 1);
    pin("rst_tag", SEL_TAG, 0);
    idle();

    // Predict T,N,T -> tags 0,1,2 and history 101
    pin("tnt_tag0", SEL_TAG, 0);
    cyc(0, 0, 1, 1, 0, '0, 0, 0);
    pin("tnt_tag1", SEL_TAG, 1);
    cyc(0, 0, 1, 0, 0, '0, 0, 0);
    pin("tnt_tag2", SEL_TAG, 2);
    cyc(0, 0, 1, 1, 0, '0, 0, 0);
    pin("tnt_ghr", SEL_GHR, 32'h0005);
    idle();

    // Mispredict tag 1 taken -> snapshot 0001 with 1 shifted in
    cyc(0, 0, 0, 0, 1, 3'd1, 1, 1);
    pin("mp_ghr", SEL_GHR, 32'h0003);
    pin("mp_tag", SEL_TAG, 2);
    idle();
    // Tag 2 was squashed: a mispredict on it must be ignored
    cyc(0, 0, 0, 0, 1, 3'd2, 1, 0);
    pin("stale_ghr", SEL_GHR, 32'h0003);
    pin("stale_tag", SEL_TAG, 2);
    idle();

    // Fill all checkpoints, then a 9th prediction is dropped
    cyc(0, 1, 0, 0, 0, '0, 0, 0);
    for (int i = 0; i < NR; i++) cyc(0, 0, 1, 1'($urandom), 0, '0, 0, 0);
    pin("full_ready", SEL_READY, 0);
    cyc(0, 0, 1, 1, 0, '0, 0, 0);
    pin("full_ready_n", SEL_READY, 0);
`ifdef GBP_GHR_PERF_EN
    pin("full_cnt", SEL_FULL, 1);
`endif
    cyc(0, 0, 0, 0, 1, 3'd0, 0, 1);    // cycle N: resolve head correct
    pin("full_ready_n1", SEL_READY, 0);
    idle();                            // N+1: head retires
    pin("full_ready_n2", SEL_READY, 1);
    idle();                            // N+2: space again

    // Mispredict on head with a same-cycle prediction: prediction dropped
    cyc(0, 1, 0, 0, 0, '0, 0, 0);
    snap0 = m_ghr;
    cyc(0, 0, 1, 1, 0, '0, 0, 0);
    cyc(0, 0, 1, 1, 1, 3'd0, 1, 0);
    pin("mp_head_ghr", SEL_GHR, 32'({snap0[HL-2:0], 1'b0}));
    pin("mp_head_tag", SEL_TAG, 1);
    pin("mp_head_ready", SEL_READY, 1);
    idle();

    // Commit path and flush: T,T retire, N speculative, then flush
    cyc(1, 0, 0, 0, 0, '0, 0, 0);
    cyc(0, 0, 1, 1, 0, '0, 0, 0);
    cyc(0, 0, 1, 1, 0, '0, 0, 0);
    cyc(0, 0, 0, 0, 1, 3'd0, 0, 1);
    cyc(0, 0, 0, 0, 1, 3'd1, 0, 1);
    idle();
    idle();
    cyc(0, 0, 1, 0, 0, '0, 0, 0);
    cyc(0, 1, 0, 0, 0, '0, 0, 0);
    pin("flush_commit", SEL_COMMIT, 32'h0003);
    pin("flush_ghr", SEL_GHR, 32'h0003);
    pin("flush_tag", SEL_TAG, 0);
    idle();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      sz = mq.size();
      if (sz != 0 && ($urandom % 4) != 0)
        rtg = TW'((m_head + int'($urandom_range(0, sz - 1))) % NR);
      else
        rtg = TW'($urandom);
      cyc(($urandom % 500) == 0, ($urandom % 60) == 0, ($urandom % 3) != 0,
          1'($urandom), 1'($urandom), rtg, ($urandom % 5) == 0, 1'($urandom));
    end
    idle();

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    drained = (exp_q.size() == 0);
    done = 1'b1;
  end

endmodule
